// File: rtl/vga_sync_monitor.sv
// Receive-side VGA timing monitor: measures line/frame length, locks onto stable timing and
// recovers pixel coordinates. Optional frame CRC is built when VGA_MON_CRC_EN is defined.
module vga_sync_monitor #(
  parameter int unsigned H_ACTIVE    = 640,
  parameter int unsigned V_ACTIVE    = 480,
  parameter int unsigned H_BP        = 128,
  parameter int unsigned V_BP        = 28,
  parameter bit          SYNC_POL    = 1'b0,
  parameter int unsigned LOCK_FRAMES = 2
) (
  input  logic        ClockK,
  input  logic        reset,
  input  logic        h_sync,
  input  logic        v_sync,
  input  logic        red,
  input  logic        green,
  input  logic        blue,
  output logic [9:0]  x_count,
  output logic [9:0]  y_count,
  output logic        pixel_valid,
  output logic [2:0]  pix_rgb,
  output logic [10:0] h_total,
  output logic [9:0]  v_total,
  output logic        locked,
  output logic        frame_done,
  output logic        sync_err,
  output logic [15:0] frame_crc
);

  localparam logic [10:0] HLo   = 11'(H_BP);
  localparam logic [10:0] HHi   = 11'(H_BP + H_ACTIVE);
  localparam logic [9:0]  VLo   = 10'(V_BP);
  localparam logic [9:0]  VHi   = 10'(V_BP + V_ACTIVE);
  localparam logic [3:0]  LockN = 4'(LOCK_FRAMES);

  typedef enum logic [1:0] {StSearch, StTrack, StLocked} state_e;

  state_e      state_q, state_d;
  logic        h_s1_q, h_s2_q, v_s1_q, v_s2_q;
  logic [2:0]  rgb_s1_q, rgb_s2_q;
  logic [10:0] hcnt_q, hcnt_d, hpos_q, hpos_d, h_total_q, h_total_d;
  logic [9:0]  lcnt_q, lcnt_d, vpos_q, vpos_d, v_total_q, v_total_d;
  logic        vnew_q, vnew_d, err_seen_q, err_seen_d;
  logic [2:0]  good_q, good_d;
  logic        sync_err_q, sync_err_d, frame_done_q;
  logic [9:0]  x_count_q, x_count_d, y_count_q, y_count_d;
  logic [2:0]  pix_rgb_q, pix_rgb_d;
  logic        valid_q, valid_d;

  logic        h_as_edge, h_de_edge, v_as_edge, v_de_edge;
  logic        line_err, timeout, frame_err, frame_good, win;
  logic [10:0] hcnt_inc, xdiff;
  logic [9:0]  lcnt_eff, ydiff;

  // Polarity-normalised edge detection between the two sync stages
  assign h_as_edge = (h_s1_q == SYNC_POL) && (h_s2_q != SYNC_POL);
  assign h_de_edge = (h_s1_q != SYNC_POL) && (h_s2_q == SYNC_POL);
  assign v_as_edge = (v_s1_q == SYNC_POL) && (v_s2_q != SYNC_POL);
  assign v_de_edge = (v_s1_q != SYNC_POL) && (v_s2_q == SYNC_POL);

  assign hcnt_inc   = hcnt_q + 11'd1;
  assign lcnt_eff   = lcnt_q + {9'd0, h_as_edge};
  assign line_err   = h_as_edge && (lcnt_q != 10'd0) && (hcnt_inc != h_total_q);
  assign timeout    = (hcnt_q == 11'h7FF) && !h_as_edge;
  assign frame_err  = err_seen_q || line_err;
  assign frame_good = !frame_err && (lcnt_eff == v_total_q);
  assign win        = (hpos_q >= HLo) && (hpos_q < HHi) && (vpos_q >= VLo) && (vpos_q < VHi);
  assign xdiff      = hpos_q - HLo;
  assign ydiff      = vpos_q - VLo;

  always_comb begin
    hcnt_d     = h_as_edge ? 11'd0 : ((hcnt_q == 11'h7FF) ? hcnt_q : hcnt_inc);
    h_total_d  = h_as_edge ? hcnt_inc : h_total_q;
    hpos_d     = h_de_edge ? 11'd0 : ((hpos_q == 11'h7FF) ? hpos_q : hpos_q + 11'd1);
    lcnt_d     = v_as_edge ? 10'd0 : lcnt_eff;
    v_total_d  = v_as_edge ? lcnt_eff : v_total_q;
    err_seen_d = v_as_edge ? 1'b0 : frame_err;
    vpos_d     = vpos_q;
    vnew_d     = vnew_q;
    if (h_de_edge) begin
      if (vnew_q) begin
        vpos_d = 10'd0;
        vnew_d = 1'b0;
      end else if (vpos_q != 10'h3FF) begin
        vpos_d = vpos_q + 10'd1;
      end
    end
    if (v_de_edge) vnew_d = 1'b1;

    state_d    = state_q;
    good_d     = good_q;
    sync_err_d = sync_err_q;
    case (state_q)
      StSearch: begin
        if (v_as_edge) begin
          state_d = StTrack;
          good_d  = 3'd0;
        end
      end
      StTrack: begin
        if (v_as_edge) begin
          if (!frame_good) begin
            good_d = 3'd0;
          end else if (({1'b0, good_q} + 4'd1) >= LockN) begin
            state_d = StLocked;
            good_d  = 3'd0;
          end else begin
            good_d = good_q + 3'd1;
          end
        end
      end
      StLocked: begin
        if (line_err || (v_as_edge && (lcnt_eff != v_total_q))) begin
          state_d    = StSearch;
          sync_err_d = 1'b1;
        end
      end
      default: state_d = StSearch;
    endcase
    if (timeout) begin
      state_d = StSearch;
      if (state_q == StLocked) sync_err_d = 1'b1;
    end

    valid_d   = win && (state_q == StLocked);
    x_count_d = valid_d ? xdiff[9:0] : x_count_q;
    y_count_d = valid_d ? ydiff : y_count_q;
    pix_rgb_d = valid_d ? rgb_s2_q : pix_rgb_q;
  end

  always_ff @(posedge ClockK or posedge reset) begin
    if (reset) begin
      h_s1_q       <= ~SYNC_POL;
      h_s2_q       <= ~SYNC_POL;
      v_s1_q       <= ~SYNC_POL;
      v_s2_q       <= ~SYNC_POL;
      rgb_s1_q     <= 3'd0;
      rgb_s2_q     <= 3'd0;
      hcnt_q       <= 11'd0;
      hpos_q       <= 11'd0;
      h_total_q    <= 11'd0;
      lcnt_q       <= 10'd0;
      vpos_q       <= 10'd0;
      v_total_q    <= 10'd0;
      vnew_q       <= 1'b0;
      err_seen_q   <= 1'b0;
      good_q       <= 3'd0;
      state_q      <= StSearch;
      sync_err_q   <= 1'b0;
      frame_done_q <= 1'b0;
      x_count_q    <= 10'd0;
      y_count_q    <= 10'd0;
      pix_rgb_q    <= 3'd0;
      valid_q      <= 1'b0;
    end else begin
      h_s1_q       <= h_sync;
      h_s2_q       <= h_s1_q;
      v_s1_q       <= v_sync;
      v_s2_q       <= v_s1_q;
      rgb_s1_q     <= {red, green, blue};
      rgb_s2_q     <= rgb_s1_q;
      hcnt_q       <= hcnt_d;
      hpos_q       <= hpos_d;
      h_total_q    <= h_total_d;
      lcnt_q       <= lcnt_d;
      vpos_q       <= vpos_d;
      v_total_q    <= v_total_d;
      vnew_q       <= vnew_d;
      err_seen_q   <= err_seen_d;
      good_q       <= good_d;
      state_q      <= state_d;
      sync_err_q   <= sync_err_d;
      frame_done_q <= v_as_edge;
      x_count_q    <= x_count_d;
      y_count_q    <= y_count_d;
      pix_rgb_q    <= pix_rgb_d;
      valid_q      <= valid_d;
    end
  end

`ifdef VGA_MON_CRC_EN
  logic [15:0] crc_q, crc_d, frame_crc_q, frame_crc_d;

  function automatic logic [15:0] crc_step(input logic [15:0] c, input logic b);
    logic fb;
    fb = c[15] ^ b;
    return {c[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
  endfunction

  always_comb begin
    crc_d       = crc_q;
    frame_crc_d = frame_crc_q;
    if (valid_d) crc_d = crc_step(crc_step(crc_step(crc_q, rgb_s2_q[2]), rgb_s2_q[1]), rgb_s2_q[0]);
    if (v_as_edge) begin
      frame_crc_d = crc_q;
      crc_d       = 16'hFFFF;
    end
  end

  always_ff @(posedge ClockK or posedge reset) begin
    if (reset) begin
      crc_q       <= 16'hFFFF;
      frame_crc_q <= 16'h0000;
    end else begin
      crc_q       <= crc_d;
      frame_crc_q <= frame_crc_d;
    end
  end

  assign frame_crc = frame_crc_q;
`else
  assign frame_crc = 16'h0000;
`endif

  assign x_count     = x_count_q;
  assign y_count     = y_count_q;
  assign pixel_valid = valid_q;
  assign pix_rgb     = pix_rgb_q;
  assign h_total     = h_total_q;
  assign v_total     = v_total_q;
  assign locked      = (state_q == StLocked);
  assign frame_done  = frame_done_q;
  assign sync_err    = sync_err_q;

endmodule

// File: tb/tb_vga_sync_monitor.sv
// Directed bench for vga_sync_monitor using a scaled-down 30x15 raster (16x8 active).
module tb_vga_sync_monitor;

  localparam int HSync = 4, HBp = 6, HAct = 16, HTot = 30;
  localparam int VSync = 2, VBp = 3, VAct = 8, VTot = 15;

  logic        ClockK = 1'b0;
  logic        reset = 1'b1;
  logic        h_sync = 1'b1, v_sync = 1'b1, red = 1'b0, green = 1'b0, blue = 1'b0;
  logic [9:0]  x_count, y_count, v_total;
  logic [10:0] h_total;
  logic [2:0]  pix_rgb;
  logic        pixel_valid, locked, frame_done, sync_err;
  logic [15:0] frame_crc;

  int n_checks = 0;
  int n_fail   = 0;

  // Per-frame statistics latched at each frame_done
  int          valid_run = 0, red_run = 0, valid_total = 0;
  int          last_valid = 0, last_red = 0;
  logic [9:0]  run_x = '0, run_y = '0, last_x = '0, last_y = '0;
  logic [2:0]  run_rgb = '0, last_rgb = '0;
  logic [15:0] last_crc = '0;

  vga_sync_monitor #(
    .H_ACTIVE   (HAct),
    .V_ACTIVE   (VAct),
    .H_BP       (HBp),
    .V_BP       (VBp),
    .SYNC_POL   (1'b0),
    .LOCK_FRAMES(2)
  ) dut (
    .ClockK     (ClockK),
    .reset      (reset),
    .h_sync     (h_sync),
    .v_sync     (v_sync),
    .red        (red),
    .green      (green),
    .blue       (blue),
    .x_count    (x_count),
    .y_count    (y_count),
    .pixel_valid(pixel_valid),
    .pix_rgb    (pix_rgb),
    .h_total    (h_total),
    .v_total    (v_total),
    .locked     (locked),
    .frame_done (frame_done),
    .sync_err   (sync_err),
    .frame_crc  (frame_crc)
  );

  always #5 ClockK = ~ClockK;

  always @(negedge ClockK) begin
    if (pixel_valid) begin
      valid_run   <= valid_run + 1;
      valid_total <= valid_total + 1;
      if (pix_rgb != 3'd0) begin
        red_run <= red_run + 1;
        run_x   <= x_count;
        run_y   <= y_count;
        run_rgb <= pix_rgb;
      end
    end
    if (frame_done) begin
      last_valid <= valid_run;
      last_red   <= red_run;
      last_x     <= run_x;
      last_y     <= run_y;
      last_rgb   <= run_rgb;
      last_crc   <= frame_crc;
      valid_run  <= 0;
      red_run    <= 0;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

`ifdef VGA_MON_CRC_EN
  function automatic logic [15:0] crc_model(input bit flip);
    logic [15:0] c;
    logic [2:0]  px;
    c = 16'hFFFF;
    for (int y = 0; y < VAct; y++) begin
      for (int x = 0; x < HAct; x++) begin
        px = {(x == 10 && y == 5), (flip && x == 3 && y == 2), 1'b0};
        for (int b = 2; b >= 0; b--) begin
          c = (c[15] ^ px[b]) ? ({c[14:0], 1'b0} ^ 16'h1021) : {c[14:0], 1'b0};
        end
      end
    end
    return c;
  endfunction
`endif

  task automatic check_crc(input string tag, input bit flip);
`ifdef VGA_MON_CRC_EN
    check_eq(tag, {16'd0, last_crc}, {16'd0, crc_model(flip)});
`else
    check_eq(tag, {16'd0, last_crc}, 32'd0);
    check_eq({tag, "_pin"}, {16'd0, frame_crc}, 32'd0);
`endif
  endtask

  // One frame of stimulus; red at active (10,5), optional green flip at (3,2), an optional
  // stretched line and an optional one-cycle reset pulse at column 12 of a given line.
  task automatic gen_frame(input int stretch_line, input bit flip, input int reset_line);
    int len, px, py;
    for (int l = 0; l < VTot; l++) begin
      len = (l == stretch_line) ? HTot + 1 : HTot;
      for (int c = 0; c < len; c++) begin
        @(posedge ClockK);
        #1;
        px     = c - HSync - HBp;
        py     = l - VSync - VBp;
        h_sync = (c < HSync) ? 1'b0 : 1'b1;
        v_sync = (l < VSync) ? 1'b0 : 1'b1;
        red    = (px == 10 && py == 5);
        green  = flip && (px == 3) && (py == 2);
        blue   = 1'b0;
        reset  = (l == reset_line && c == 12);
        if (reset) begin
          @(negedge ClockK);
          check_eq("mid_rst_locked", {31'd0, locked}, 32'd0);
          check_eq("mid_rst_sync_err", {31'd0, sync_err}, 32'd0);
          check_eq("mid_rst_h_total", {21'd0, h_total}, 32'd0);
          check_eq("mid_rst_v_total", {22'd0, v_total}, 32'd0);
          check_eq("mid_rst_valid", {31'd0, pixel_valid}, 32'd0);
          check_eq("mid_rst_x", {22'd0, x_count}, 32'd0);
          check_eq("mid_rst_y", {22'd0, y_count}, 32'd0);
        end
      end
    end
    @(negedge ClockK);
  endtask

  initial begin
    int snap;
    repeat (3) @(posedge ClockK);
    @(negedge ClockK);
    check_eq("rst_x", {22'd0, x_count}, 32'd0);
    check_eq("rst_y", {22'd0, y_count}, 32'd0);
    check_eq("rst_valid", {31'd0, pixel_valid}, 32'd0);
    check_eq("rst_rgb", {29'd0, pix_rgb}, 32'd0);
    check_eq("rst_h_total", {21'd0, h_total}, 32'd0);
    check_eq("rst_v_total", {22'd0, v_total}, 32'd0);
    check_eq("rst_locked", {31'd0, locked}, 32'd0);
    check_eq("rst_frame_done", {31'd0, frame_done}, 32'd0);
    check_eq("rst_sync_err", {31'd0, sync_err}, 32'd0);
    check_eq("rst_frame_crc", {16'd0, frame_crc}, 32'd0);

    // Acquisition: SEARCH at frame 1 start, good frames 2 and 3, lock at frame 4 start
    for (int f = 1; f <= 3; f++) gen_frame(-1, 1'b0, -1);
    check_eq("lock_early", {31'd0, locked}, 32'd0);
    gen_frame(-1, 1'b0, -1);
    check_eq("lock_f4", {31'd0, locked}, 32'd1);

    gen_frame(-1, 1'b0, -1);
    check_eq("h_total", {21'd0, h_total}, HTot);
    check_eq("v_total", {22'd0, v_total}, VTot);
    check_eq("valid_per_frame", last_valid, HAct * VAct);
    check_eq("red_hits", last_red, 1);
    check_eq("red_x", {22'd0, last_x}, 10);
    check_eq("red_y", {22'd0, last_y}, 5);
    check_eq("red_rgb", {29'd0, last_rgb}, 32'h4);
    check_crc("crc_f4", 1'b0);

    gen_frame(-1, 1'b1, -1);
    check_crc("crc_f5", 1'b0);
    gen_frame(-1, 1'b0, -1);
    check_crc("crc_f6_flip", 1'b1);

    // Stretched line while locked: drop lock, then relock after two good frames
    gen_frame(7, 1'b0, -1);
    check_eq("stretch_locked", {31'd0, locked}, 32'd0);
    check_eq("stretch_sync_err", {31'd0, sync_err}, 32'd1);
    gen_frame(-1, 1'b0, -1);
    gen_frame(-1, 1'b0, -1);
    check_eq("relock_early", {31'd0, locked}, 32'd0);
    gen_frame(-1, 1'b0, -1);
    check_eq("relock", {31'd0, locked}, 32'd1);
    check_eq("sync_err_sticky", {31'd0, sync_err}, 32'd1);

    // Mid-line reset: full reacquisition needed afterwards
    gen_frame(-1, 1'b0, 6);
    for (int f = 0; f < 3; f++) gen_frame(-1, 1'b0, -1);
    check_eq("post_rst_lock_early", {31'd0, locked}, 32'd0);
    gen_frame(-1, 1'b0, -1);
    check_eq("post_rst_lock", {31'd0, locked}, 32'd1);
    check_eq("post_rst_sync_err", {31'd0, sync_err}, 32'd0);
    gen_frame(-1, 1'b0, -1);
    check_eq("post_rst_h_total", {21'd0, h_total}, HTot);

    // Hsync held inactive: line counter saturates and times out
    snap = valid_total;
    h_sync = 1'b1;
    v_sync = 1'b1;
    red    = 1'b0;
    green  = 1'b0;
    repeat (2200) @(posedge ClockK);
    @(negedge ClockK);
    check_eq("timeout_locked", {31'd0, locked}, 32'd0);
    check_eq("timeout_sync_err", {31'd0, sync_err}, 32'd1);
    check_eq("timeout_no_valid", valid_total - snap, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/vga_sync_monitor.md
# vga_sync_monitor

- Receive-side counterpart of the VGA timing generator: consumes the `h_sync`, `v_sync`, `red`, `green`, `blue` stream on the pixel clock.
- Measures line and frame length and declares lock after consecutive stable frames.
- Recovers `x_count`/`y_count` for each active pixel.
- Used as an on-board self-test and loopback checker for the pong video path, alongside the generator in the top level.

## Interface
Parameters:
- `H_ACTIVE`, 640, active pixels per line
- `V_ACTIVE`, 480, active lines per frame
- `H_BP`, 128, clocks from hsync deassert to first active pixel
- `V_BP`, 28, lines from vsync deassert to first active line
- `SYNC_POL`, 0, asserted level of both syncs (0 = active-low)
- `LOCK_FRAMES`, 2, consecutive good frames required for lock (1..7)

Ports:
- `ClockK` in 1: pixel clock (31.5 MHz); the only clock.
- `reset` in 1: asynchronous, active-high.
- `h_sync`, `v_sync` in 1: sync inputs.
- `red`, `green`, `blue` in 1: colour inputs.
- `x_count` out 10: recovered column, valid when `pixel_valid`.
- `y_count` out 10: recovered row, valid when `pixel_valid`.
- `pixel_valid` out 1: current pixel is inside the active window and `locked`=1.
- `pix_rgb` out 3: {red,green,blue} aligned with `x_count`/`y_count`.
- `h_total` out 11: last measured line length in clocks.
- `v_total` out 10: last measured frame length in lines.
- `locked` out 1: timing stable.
- `frame_done` out 1: one-cycle pulse at each vsync assert edge.
- `sync_err` out 1: sticky; cleared only by `reset`.
- `frame_crc` out 16: CRC of the previous frame's active pixels.

## Operation
- **Input stage:** inputs are registered twice (s1, s2). Edges are detected by comparing s1 against s2, with sync polarity normalised by `SYNC_POL`.
- **Horizontal, `hcnt` (11 b):**
  - At the h-assert edge: `h_total`←`hcnt`+1, then `hcnt`←0.
  - Otherwise `hcnt` increments, saturating at 2047.
  - Saturation is a timeout error.
- **Horizontal position, `hpos` (11 b):** cleared at the h-deassert edge, increments otherwise, saturates at 2047.
- **Lines per frame, `lcnt` (10 b):** incremented at each h-assert edge. At the v-assert edge: `v_total`←`lcnt`, then `lcnt`←0.
- **Vertical position, `vpos` (10 b):**
  - The v-deassert edge sets flag `vnew`.
  - At the next h-deassert edge: `vpos`←0 if `vnew` is set (and `vnew` is cleared), else `vpos`←`vpos`+1.
- **Active window:** `hpos` in [`H_BP`, `H_BP`+`H_ACTIVE`) and `vpos` in [`V_BP`, `V_BP`+`V_ACTIVE`).
  - `x_count`=`hpos`−`H_BP`, `y_count`=`vpos`−`V_BP`.
  - Outside the window, `x_count`/`y_count` hold their last values.
- **Line error:** any h-assert edge where `hcnt`+1 ≠ current `h_total`, after the first line of a frame.
- **Lock FSM:**
  - SEARCH: first v-assert edge → TRACK; good-frame count ←0.
  - TRACK:
    - At a v-assert edge with no line error this frame and `lcnt`==previous `v_total`: good-frame count +1.
    - When the count reaches `LOCK_FRAMES`: → LOCKED, `locked`←1.
    - Any error: count ←0, stay in TRACK.
  - LOCKED: any line error, frame-length mismatch or timeout → SEARCH, `locked`←0, `sync_err`←1.
  - Any timeout in any state → SEARCH.
- **Simultaneous h-assert and v-assert edges:** the line is counted first, then `v_total` is latched. The line counts toward the ending frame.

## Timing
- Reset values:
  - All outputs 0; FSM in SEARCH.
  - All counters 0; `vnew` clear.
  - CRC register 0xFFFF.
- Sync and colour events are visible at the outputs 3 `ClockK` cycles after the input pin change (two sync stages plus one output register).
- `pixel_valid`, `x_count`, `y_count` and `pix_rgb` change together in the same cycle.
- `frame_done` and updates to `v_total`, `locked` and `frame_crc` occur in the same cycle.
- `reset` asserted mid-frame clears everything immediately. After release, lock requires a full SEARCH → TRACK sequence again.

## Configuration
- `VGA_MON_CRC_EN` defined:
  - CRC-16-CCITT (poly 0x1021, init 0xFFFF, no reflection, no final xor) runs over the active pixels.
  - Per valid pixel, 3 bits are shifted in: red first, then green, then blue.
  - At `frame_done`, the CRC value goes to `frame_crc` and the register is reset to 0xFFFF.
- `VGA_MON_CRC_EN` undefined: no CRC logic; `frame_crc` is tied to 0.

## Test plan
- Apply reset mid-line with a running 832×520 stream → all outputs 0 on the next cycle; `locked` rises only at the start (v-assert edge) of the 4th full frame after release: SEARCH, then 2 good frames.
- Nominal 832×520 stream, `SYNC_POL`=0, 40-clock hsync, 3-line vsync → `h_total`=832, `v_total`=520, `locked`=1, and exactly 640×480 `pixel_valid` cycles per frame.
- Red=1 only at pixel (10,5) → exactly one `pixel_valid` cycle per frame with `pix_rgb`=3'b100, `x_count`=10, `y_count`=5.
- One line stretched to 833 clocks while locked → `locked`=0 and `sync_err`=1 at that h-assert edge; `locked` returns after 2 good frames; `sync_err` stays 1.
- Hsync held inactive → `hcnt` saturates at 2047, `locked`=0, `sync_err`=1, no `pixel_valid`.
- With the macro defined: two identical frames → equal nonzero `frame_crc`; flipping one pixel → different `frame_crc`. With the macro undefined: `frame_crc`=0 throughout.
